id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding front end of the EX stage. Registers

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/operand_forward_unit.sv | 36 +++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: widths, ALU op codes, operand-select and forwarding codes.
// Imported by the ID/EX stage, its forwarding unit and the ALU.
package riscv_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 4;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [ALU_OP_WIDTH-1:0]   alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SLL  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_SLT  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;
  localparam alu_op_t ALU_LUI  = 4'b1010;
  localparam alu_op_t ALU_LINK = 4'b1101;

  // A bubble must look like a harmless ADD with every side effect disabled
  localparam alu_op_t ALU_BUBBLE = ALU_ADD;

  localparam logic [1:0] A_SEL_RS1 = 2'b00;
  localparam logic [1:0] A_SEL_PC  = 2'b01;
  localparam logic [1:0] A_SEL_PC4 = 2'b10;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    alu_op_t    alu_op;
    data_t      rs1_data;
    data_t      rs2_data;
    reg_addr_t  rs1_addr;
    reg_addr_t  rs2_addr;
    reg_addr_t  rd_addr;
    data_t      imm;
    data_t      pc;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, MEM/WB producer taps, pipeline control and EX outputs.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic       Stall_i;
  logic       Flush_i;
  logic       ID_Valid_i;
  alu_op_t    ID_ALU_Operation_i;
  data_t      ID_Rs1_Data_i;
  data_t      ID_Rs2_Data_i;
  reg_addr_t  ID_Rs1_Addr_i;
  reg_addr_t  ID_Rs2_Addr_i;
  reg_addr_t  ID_Rd_Addr_i;
  data_t      ID_Imm_i;
  data_t      ID_PC_i;
  logic [1:0] ID_A_Sel_i;
  logic       ID_B_Sel_i;
  logic       ID_Reg_Write_i;
  logic       ID_Mem_Read_i;
  logic       ID_Mem_Write_i;
  logic       ID_Mem_To_Reg_i;
  logic       MEM_Reg_Write_i;
  reg_addr_t  MEM_Rd_Addr_i;
  data_t      MEM_ALU_Result_i;
  logic       WB_Reg_Write_i;
  reg_addr_t  WB_Rd_Addr_i;
  data_t      WB_Data_i;

  logic       EX_Valid_o;
  alu_op_t    EX_ALU_Operation_o;
  data_t      EX_A_o;
  data_t      EX_B_o;
  data_t      EX_Store_Data_o;
  reg_addr_t  EX_Rd_Addr_o;
  logic       EX_Reg_Write_o;
  logic       EX_Mem_Read_o;
  logic       EX_Mem_Write_o;
  logic       EX_Mem_To_Reg_o;
  logic       Load_Use_Stall_o;

  modport master (
    output Stall_i, Flush_i, ID_Valid_i, ID_ALU_Operation_i, ID_Rs1_Data_i, ID_Rs2_Data_i,
           ID_Rs1_Addr_i, ID_Rs2_Addr_i, ID_Rd_Addr_i, ID_Imm_i, ID_PC_i, ID_A_Sel_i,
           ID_B_Sel_i, ID_Reg_Write_i, ID_Mem_Read_i, ID_Mem_Write_i, ID_Mem_To_Reg_i,
           MEM_Reg_Write_i, MEM_Rd_Addr_i, MEM_ALU_Result_i,
           WB_Reg_Write_i, WB_Rd_Addr_i, WB_Data_i,
    input  EX_Valid_o, EX_ALU_Operation_o, EX_A_o, EX_B_o, EX_Store_Data_o, EX_Rd_Addr_o,
           EX_Reg_Write_o, EX_Mem_Read_o, EX_Mem_Write_o, EX_Mem_To_Reg_o, Load_Use_Stall_o
  );

  modport slave (
    input  Stall_i, Flush_i, ID_Valid_i, ID_ALU_Operation_i, ID_Rs1_Data_i, ID_Rs2_Data_i,
           ID_Rs1_Addr_i, ID_Rs2_Addr_i, ID_Rd_Addr_i, ID_Imm_i, ID_PC_i, ID_A_Sel_i,
           ID_B_Sel_i, ID_Reg_Write_i, ID_Mem_Read_i, ID_Mem_Write_i, ID_Mem_To_Reg_i,
           MEM_Reg_Write_i, MEM_Rd_Addr_i, MEM_ALU_Result_i,
           WB_Reg_Write_i, WB_Rd_Addr_i, WB_Data_i,
    output EX_Valid_o, EX_ALU_Operation_o, EX_A_o, EX_B_o, EX_Store_Data_o, EX_Rd_Addr_o,
           EX_Reg_Write_o, EX_Mem_Read_o, EX_Mem_Write_o, EX_Mem_To_Reg_o, Load_Use_Stall_o
  );

endinterface

// File: rtl/operand_forward_unit.sv
// Picks one EX source operand: MEM producer first, then WB producer, else the registered value.
// Purely combinational; x0 is never forwarded.
module operand_forward_unit
  import riscv_pkg::*;
(
  input  reg_addr_t rs_addr_i,
  input  data_t     reg_data_i,
  input  logic      mem_reg_write_i,
  input  reg_addr_t mem_rd_addr_i,
  input  data_t     mem_data_i,
  input  logic      wb_reg_write_i,
  input  reg_addr_t wb_rd_addr_i,
  input  data_t     wb_data_i,
  output data_t     fwd_data_o
);

  fwd_sel_e fwd_sel;

  always_comb begin
    fwd_sel = FWD_NONE;
    if (mem_reg_write_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == rs_addr_i)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs_addr_i)) begin
      fwd_sel = FWD_WB;
    end
  end

  always_comb begin
    case (fwd_sel)
      FWD_MEM: fwd_data_o = mem_data_i;
      FWD_WB:  fwd_data_o = wb_data_i;
      default: fwd_data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and load-use bubble insertion.
// Decoded fields reach EX one cycle after capture; operands are muxed combinationally.
module id_ex_stage
  import riscv_pkg::*;
(
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  id_ex_t ex_q;
  id_ex_t ex_d;
  data_t  rs1_fwd;
  data_t  rs2_fwd;
  logic   load_use_stall;

  operand_forward_unit u_fwd_rs1 (
    .rs_addr_i       (ex_q.rs1_addr),
    .reg_data_i      (ex_q.rs1_data),
    .mem_reg_write_i (bus.MEM_Reg_Write_i),
    .mem_rd_addr_i   (bus.MEM_Rd_Addr_i),
    .mem_data_i      (bus.MEM_ALU_Result_i),
    .wb_reg_write_i  (bus.WB_Reg_Write_i),
    .wb_rd_addr_i    (bus.WB_Rd_Addr_i),
    .wb_data_i       (bus.WB_Data_i),
    .fwd_data_o      (rs1_fwd)
  );

  operand_forward_unit u_fwd_rs2 (
    .rs_addr_i       (ex_q.rs2_addr),
    .reg_data_i      (ex_q.rs2_data),
    .mem_reg_write_i (bus.MEM_Reg_Write_i),
    .mem_rd_addr_i   (bus.MEM_Rd_Addr_i),
    .mem_data_i      (bus.MEM_ALU_Result_i),
    .wb_reg_write_i  (bus.WB_Reg_Write_i),
    .wb_rd_addr_i    (bus.WB_Rd_Addr_i),
    .wb_data_i       (bus.WB_Data_i),
    .fwd_data_o      (rs2_fwd)
  );

  // Both sources are compared even for instructions that ignore rs2: cheaper than decoding.
  always_comb begin
    load_use_stall = !bus.Flush_i && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                     bus.ID_Valid_i &&
                     ((ex_q.rd_addr == bus.ID_Rs1_Addr_i) || (ex_q.rd_addr == bus.ID_Rs2_Addr_i));
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.Flush_i) begin
      ex_d        = '0;
      ex_d.alu_op = ALU_BUBBLE;
    end else if (bus.Stall_i) begin
      // Refresh held operands so they survive the producer retiring out of MEM/WB
      ex_d.rs1_data = rs1_fwd;
      ex_d.rs2_data = rs2_fwd;
    end else if (load_use_stall) begin
      ex_d        = '0;
      ex_d.alu_op = ALU_BUBBLE;
    end else begin
      ex_d.valid      = bus.ID_Valid_i;
      ex_d.alu_op     = bus.ID_ALU_Operation_i;
      ex_d.rs1_addr   = bus.ID_Rs1_Addr_i;
      ex_d.rs2_addr   = bus.ID_Rs2_Addr_i;
      ex_d.rd_addr    = bus.ID_Rd_Addr_i;
      ex_d.imm        = bus.ID_Imm_i;
      ex_d.pc         = bus.ID_PC_i;
      ex_d.a_sel      = bus.ID_A_Sel_i;
      ex_d.b_sel      = bus.ID_B_Sel_i;
      ex_d.reg_write  = bus.ID_Reg_Write_i;
      ex_d.mem_read   = bus.ID_Mem_Read_i;
      ex_d.mem_write  = bus.ID_Mem_Write_i;
      ex_d.mem_to_reg = bus.ID_Mem_To_Reg_i;
      ex_d.rs1_data   = (bus.WB_Reg_Write_i && (bus.WB_Rd_Addr_i != '0) &&
                         (bus.WB_Rd_Addr_i == bus.ID_Rs1_Addr_i)) ? bus.WB_Data_i : bus.ID_Rs1_Data_i;
      ex_d.rs2_data   = (bus.WB_Reg_Write_i && (bus.WB_Rd_Addr_i != '0) &&
                         (bus.WB_Rd_Addr_i == bus.ID_Rs2_Addr_i)) ? bus.WB_Data_i : bus.ID_Rs2_Data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    case (ex_q.a_sel)
      A_SEL_RS1: bus.EX_A_o = rs1_fwd;
      A_SEL_PC:  bus.EX_A_o = ex_q.pc;
      A_SEL_PC4: bus.EX_A_o = ex_q.pc + 32'd4;
      default:   bus.EX_A_o = '0;
    endcase
  end

  assign bus.EX_B_o             = (ex_q.b_sel == B_SEL_IMM) ? ex_q.imm : rs2_fwd;
  assign bus.EX_Store_Data_o    = rs2_fwd;
  assign bus.EX_Valid_o         = ex_q.valid;
  assign bus.EX_ALU_Operation_o = ex_q.alu_op;
  assign bus.EX_Rd_Addr_o       = ex_q.rd_addr;
  assign bus.EX_Reg_Write_o     = ex_q.reg_write;
  assign bus.EX_Mem_Read_o      = ex_q.mem_read;
  assign bus.EX_Mem_Write_o     = ex_q.mem_write;
  assign bus.EX_Mem_To_Reg_o    = ex_q.mem_to_reg;
  assign bus.Load_Use_Stall_o   = load_use_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// both checked against a cycle-level reference model of the EX register.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        valid;
    bit [3:0]  op;
    bit [31:0] r1, r2, imm, pc;
    bit [4:0]  a1, a2, rd;
    bit [1:0]  asel;
    bit        bsel, rw, mr, mw, m2r;
  } model_t;

  model_t m;
  model_t mn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] regval);
    if (bus.MEM_Reg_Write_i && a != 0 && bus.MEM_Rd_Addr_i == a) return bus.MEM_ALU_Result_i;
    if (bus.WB_Reg_Write_i && a != 0 && bus.WB_Rd_Addr_i == a) return bus.WB_Data_i;
    return regval;
  endfunction

  function automatic bit exp_lu();
    if (bus.Flush_i || !m.valid || !m.mr || m.rd == 0 || !bus.ID_Valid_i) return 1'b0;
    return (m.rd == bus.ID_Rs1_Addr_i) || (m.rd == bus.ID_Rs2_Addr_i);
  endfunction

  function automatic bit [31:0] exp_a();
    case (m.asel)
      2'd0:    return fwd(m.a1, m.r1);
      2'd1:    return m.pc;
      2'd2:    return m.pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("valid",  {31'd0, bus.EX_Valid_o}, {31'd0, m.valid});
    chk("op",     {28'd0, bus.EX_ALU_Operation_o}, {28'd0, m.op});
    chk("a",      bus.EX_A_o, exp_a());
    chk("b",      bus.EX_B_o, m.bsel ? m.imm : fwd(m.a2, m.r2));
    chk("store",  bus.EX_Store_Data_o, fwd(m.a2, m.r2));
    chk("rd",     {27'd0, bus.EX_Rd_Addr_o}, {27'd0, m.rd});
    chk("ctrl",   {28'd0, bus.EX_Reg_Write_o, bus.EX_Mem_Read_o, bus.EX_Mem_Write_o, bus.EX_Mem_To_Reg_o},
                  {28'd0, m.rw, m.mr, m.mw, m.m2r});
    chk("lu",     {31'd0, bus.Load_Use_Stall_o}, {31'd0, exp_lu()});
  endtask

  function automatic model_t predict();
    model_t n;
    model_t bubble;
    bubble = '{default: 0};
    n = m;
    if (reset) n = bubble;
    else if (bus.Flush_i) n = bubble;
    else if (bus.Stall_i) begin
      n.r1 = fwd(m.a1, m.r1);
      n.r2 = fwd(m.a2, m.r2);
    end else if (exp_lu()) n = bubble;
    else begin
      n.valid = bus.ID_Valid_i;     n.op   = bus.ID_ALU_Operation_i;
      n.a1    = bus.ID_Rs1_Addr_i;  n.a2   = bus.ID_Rs2_Addr_i;  n.rd = bus.ID_Rd_Addr_i;
      n.imm   = bus.ID_Imm_i;       n.pc   = bus.ID_PC_i;
      n.asel  = bus.ID_A_Sel_i;     n.bsel = bus.ID_B_Sel_i;
      n.rw    = bus.ID_Reg_Write_i; n.mr   = bus.ID_Mem_Read_i;
      n.mw    = bus.ID_Mem_Write_i; n.m2r  = bus.ID_Mem_To_Reg_i;
      n.r1 = (bus.WB_Reg_Write_i && bus.ID_Rs1_Addr_i != 0 && bus.WB_Rd_Addr_i == bus.ID_Rs1_Addr_i)
             ? bus.WB_Data_i : bus.ID_Rs1_Data_i;
      n.r2 = (bus.WB_Reg_Write_i && bus.ID_Rs2_Addr_i != 0 && bus.WB_Rd_Addr_i == bus.ID_Rs2_Addr_i)
             ? bus.WB_Data_i : bus.ID_Rs2_Data_i;
    end
    return n;
  endfunction

  task automatic tick();
    @(negedge clk);
    check_outputs();
    mn = predict();
    @(posedge clk);
    #1;
    m = mn;
  endtask

  task automatic idle_inputs();
    bus.Stall_i = 0; bus.Flush_i = 0; bus.ID_Valid_i = 0; bus.ID_ALU_Operation_i = 0;
    bus.ID_Rs1_Data_i = 0; bus.ID_Rs2_Data_i = 0; bus.ID_Rs1_Addr_i = 0; bus.ID_Rs2_Addr_i = 0;
    bus.ID_Rd_Addr_i = 0; bus.ID_Imm_i = 0; bus.ID_PC_i = 0; bus.ID_A_Sel_i = 0; bus.ID_B_Sel_i = 0;
    bus.ID_Reg_Write_i = 0; bus.ID_Mem_Read_i = 0; bus.ID_Mem_Write_i = 0; bus.ID_Mem_To_Reg_i = 0;
    bus.MEM_Reg_Write_i = 0; bus.MEM_Rd_Addr_i = 0; bus.MEM_ALU_Result_i = 0;
    bus.WB_Reg_Write_i = 0; bus.WB_Rd_Addr_i = 0; bus.WB_Data_i = 0;
  endtask

  task automatic random_inputs();
    reset = ($urandom_range(0, 49) == 0);
    bus.Stall_i = ($urandom_range(0, 7) == 0); bus.Flush_i = ($urandom_range(0, 9) == 0);
    bus.ID_Valid_i = ($urandom_range(0, 3) != 0); bus.ID_ALU_Operation_i = 4'($urandom);
    bus.ID_Rs1_Data_i = $urandom; bus.ID_Rs2_Data_i = $urandom;
    bus.ID_Rs1_Addr_i = 5'($urandom_range(0, 7)); bus.ID_Rs2_Addr_i = 5'($urandom_range(0, 7));
    bus.ID_Rd_Addr_i = 5'($urandom_range(0, 7)); bus.ID_Imm_i = $urandom; bus.ID_PC_i = $urandom;
    bus.ID_A_Sel_i = 2'($urandom); bus.ID_B_Sel_i = 1'($urandom);
    bus.ID_Reg_Write_i = 1'($urandom); bus.ID_Mem_Read_i = 1'($urandom);
    bus.ID_Mem_Write_i = 1'($urandom); bus.ID_Mem_To_Reg_i = 1'($urandom);
    bus.MEM_Reg_Write_i = 1'($urandom); bus.MEM_Rd_Addr_i = 5'($urandom_range(0, 7));
    bus.MEM_ALU_Result_i = $urandom;
    bus.WB_Reg_Write_i = 1'($urandom); bus.WB_Rd_Addr_i = 5'($urandom_range(0, 7));
    bus.WB_Data_i = $urandom;
  endtask

  initial begin
    idle_inputs();
    m = '{default: 0};
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("por_valid", {31'd0, bus.EX_Valid_o}, 32'd0);
    chk("por_a", bus.EX_A_o, 32'd0);
    chk("por_lu", {31'd0, bus.Load_Use_Stall_o}, 32'd0);

    // MEM beats WB, WB beats register data
    bus.ID_Valid_i = 1; bus.ID_Rs1_Addr_i = 5'd3; bus.ID_Rs1_Data_i = 32'h5; bus.ID_Rd_Addr_i = 5'd7;
    tick();
    idle_inputs();
    bus.MEM_Reg_Write_i = 1; bus.MEM_Rd_Addr_i = 5'd3; bus.MEM_ALU_Result_i = 32'h10;
    bus.WB_Reg_Write_i = 1;  bus.WB_Rd_Addr_i = 5'd3;  bus.WB_Data_i = 32'h20;
    #1 chk("fwd_mem_prio", bus.EX_A_o, 32'h10);
    bus.MEM_Reg_Write_i = 0;
    #1 chk("fwd_wb", bus.EX_A_o, 32'h20);
    bus.WB_Reg_Write_i = 0;
    #1 chk("fwd_none", bus.EX_A_o, 32'h5);
    tick();

    // x0 is never forwarded, neither at capture nor in EX
    bus.ID_Valid_i = 1; bus.ID_Rs1_Addr_i = 5'd0; bus.ID_Rs1_Data_i = 32'h0;
    bus.WB_Reg_Write_i = 1; bus.WB_Rd_Addr_i = 5'd0; bus.WB_Data_i = 32'hFF;
    tick();
    bus.MEM_Reg_Write_i = 1; bus.MEM_Rd_Addr_i = 5'd0; bus.MEM_ALU_Result_i = 32'hFF;
    #1 chk("x0_no_fwd", bus.EX_A_o, 32'h0);
    tick();
    idle_inputs();

    // ID capture bypass from WB
    bus.ID_Valid_i = 1; bus.ID_Rs1_Addr_i = 5'd4; bus.ID_Rs1_Data_i = 32'h44;
    bus.WB_Reg_Write_i = 1; bus.WB_Rd_Addr_i = 5'd4; bus.WB_Data_i = 32'h99;
    tick();
    idle_inputs();
    #1 chk("capture_bypass", bus.EX_A_o, 32'h99);
    tick();

    // Load-use: lw x5 then add using x5
    bus.ID_Valid_i = 1; bus.ID_Mem_Read_i = 1; bus.ID_Reg_Write_i = 1; bus.ID_Mem_To_Reg_i = 1;
    bus.ID_Rd_Addr_i = 5'd5; bus.ID_Rs1_Addr_i = 5'd1;
    tick();
    idle_inputs();
    bus.ID_Valid_i = 1; bus.ID_Rs1_Addr_i = 5'd5; bus.ID_Rs2_Addr_i = 5'd6;
    bus.ID_Rd_Addr_i = 5'd8; bus.ID_Reg_Write_i = 1; bus.ID_ALU_Operation_i = 4'b0000;
    #1 chk("lu_raise", {31'd0, bus.Load_Use_Stall_o}, 32'd1);
    tick();
    #1 chk("lu_bubble_valid", {31'd0, bus.EX_Valid_o}, 32'd0);
    chk("lu_bubble_rw", {31'd0, bus.EX_Reg_Write_o}, 32'd0);
    chk("lu_bubble_op", {28'd0, bus.EX_ALU_Operation_o}, 32'd0);
    tick();
    #1 chk("lu_add_loaded", {27'd0, bus.EX_Rd_Addr_o}, 32'd8);
    chk("lu_add_valid", {31'd0, bus.EX_Valid_o}, 32'd1);
    idle_inputs();

    // Stall holds and refreshes operand from a retiring WB producer
    bus.ID_Valid_i = 1; bus.ID_Rs2_Addr_i = 5'd9; bus.ID_Rs2_Data_i = 32'h11; bus.ID_Rd_Addr_i = 5'd10;
    tick();
    bus.ID_Rd_Addr_i = 5'd12; bus.Stall_i = 1;
    bus.WB_Reg_Write_i = 1; bus.WB_Rd_Addr_i = 5'd9; bus.WB_Data_i = 32'h33;
    #1 chk("stall_b_c1", bus.EX_B_o, 32'h33);
    tick();
    bus.WB_Reg_Write_i = 0;
    #1 chk("stall_b_c2", bus.EX_B_o, 32'h33);
    chk("stall_rd_hold", {27'd0, bus.EX_Rd_Addr_o}, 32'd10);
    tick();
    bus.Stall_i = 0;
    #1 chk("stall_b_after", bus.EX_B_o, 32'h33);

    // Flush dominates stall and masks load-use; then jal operand PC+4
    idle_inputs();
    bus.ID_Valid_i = 1; bus.ID_Mem_Read_i = 1; bus.ID_Rd_Addr_i = 5'd2;
    tick();
    idle_inputs();
    bus.ID_Valid_i = 1; bus.ID_Rs1_Addr_i = 5'd2; bus.Flush_i = 1; bus.Stall_i = 1;
    #1 chk("flush_masks_lu", {31'd0, bus.Load_Use_Stall_o}, 32'd0);
    tick();
    #1 chk("flush_valid", {31'd0, bus.EX_Valid_o}, 32'd0);
    idle_inputs();
    bus.ID_Valid_i = 1; bus.ID_ALU_Operation_i = 4'b1101; bus.ID_A_Sel_i = 2'b10;
    bus.ID_PC_i = 32'h100; bus.ID_Rd_Addr_i = 5'd1; bus.ID_Reg_Write_i = 1;
    tick();
    #1 chk("jal_a", bus.EX_A_o, 32'h104);
    chk("jal_op", {28'd0, bus.EX_ALU_Operation_o}, 32'hD);

    // Reset mid-stall clears state and leaves no hold behind
    bus.Stall_i = 1;
    tick();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1 chk("rst_valid", {31'd0, bus.EX_Valid_o}, 32'd0);
    chk("rst_a", bus.EX_A_o, 32'd0);
    chk("rst_lu", {31'd0, bus.Load_Use_Stall_o}, 32'd0);
    idle_inputs();
    tick();

    for (int i = 0; i < 400; i++) begin
      random_inputs();
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
